board_square_renderer: RTL and testbench

Sequential pixel generator that paints the 3x3 tic-tac-toe board onto the VGA frame buffer. It sits directly downstream of the per-cell position/colour decoding and directly upstream of the VGA adapter. On `start`, it snapshots the 18-bit board state. It then walks all nine cells in row-major order and emits one filled SIZE x SIZE square per cell, one pixel per clock, on an `x`/`y`/`colour`/`plot` interface.

---
 rtl/board_square_renderer_if.sv | 23 ++
 rtl/board_square_renderer.sv | 129 ++++++++++++
 tb/tb_board_square_renderer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/board_square_renderer_if.sv
// Board renderer bus: redraw request and board state in, pixel stream and status out.
interface board_square_renderer_if;
  logic        start;
  logic [17:0] grid;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        plot;
  logic        busy;
  logic        done;

  // Controller side: requests redraws and consumes the pixel stream.
  modport master (
    output start, grid,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  // Renderer side.
  modport slave (
    input  start, grid,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/board_square_renderer.sv
// Paints the 3x3 tic-tac-toe board as nine filled squares, one pixel per clock,
// walking cells in row-major order from a snapshot of the board taken at start.
module board_square_renderer #(
  parameter int SIZE  = 20,
  parameter int PITCH = 30,
  parameter int X0    = 37,
  parameter int Y0    = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  board_square_renderer_if.slave bus
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);

  localparam logic [7:0] XC0 = 8'(X0);
  localparam logic [7:0] XC1 = 8'(X0 + PITCH);
  localparam logic [7:0] XC2 = 8'(X0 + 2 * PITCH);
  localparam logic [6:0] YC0 = 7'(Y0);
  localparam logic [6:0] YC1 = 7'(Y0 + PITCH);
  localparam logic [6:0] YC2 = 7'(Y0 + 2 * PITCH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [17:0]      grid_snap;
  logic [3:0]       c;
  logic [CNT_W-1:0] px;
  logic [CNT_W-1:0] py;

  logic [7:0] x_base;
  logic [6:0] y_base;
  logic [1:0] cell_code;

  // State machine and the px -> py -> cell counter chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      grid_snap <= '0;
      c         <= '0;
      px        <= '0;
      py        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_DRAW;
            grid_snap <= bus.grid;
            c         <= '0;
            px        <= '0;
            py        <= '0;
          end
        end
        S_DRAW: begin
          if (px == LAST) begin
            px <= '0;
            if (py == LAST) begin
              py <= '0;
              if (c == 4'd8) begin
                state <= S_DONE;
              end else begin
                c <= c + 4'd1;
              end
            end else begin
              py <= py + 1'b1;
            end
          end else begin
            px <= px + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Cell origin lookup (row = c/3, col = c%3) and the snapshot code of the current cell.
  always_comb begin
    x_base    = XC0;
    y_base    = YC0;
    cell_code = 2'd0;
    case (c)
      4'd0: begin x_base = XC0; y_base = YC0; end
      4'd1: begin x_base = XC1; y_base = YC0; end
      4'd2: begin x_base = XC2; y_base = YC0; end
      4'd3: begin x_base = XC0; y_base = YC1; end
      4'd4: begin x_base = XC1; y_base = YC1; end
      4'd5: begin x_base = XC2; y_base = YC1; end
      4'd6: begin x_base = XC0; y_base = YC2; end
      4'd7: begin x_base = XC1; y_base = YC2; end
      4'd8: begin x_base = XC2; y_base = YC2; end
      default: begin x_base = XC0; y_base = YC0; end
    endcase
    for (int n = 0; n < 9; n++) begin
      if (c == 4'(n)) begin
        cell_code = grid_snap[17 - 2 * n -: 2];
      end
    end
  end

  // Pixel outputs: live only while drawing, forced to zero otherwise.
  always_comb begin
    bus.plot       = 1'b0;
    bus.x_out      = 8'd0;
    bus.y_out      = 7'd0;
    bus.colour_out = 3'b000;
    bus.busy       = (state == S_DRAW);
    bus.done       = (state == S_DONE);
    if (state == S_DRAW) begin
      bus.plot  = 1'b1;
      bus.x_out = x_base + 8'(px);
      bus.y_out = y_base + 7'(py);
      case (cell_code)
        2'd0:    bus.colour_out = 3'b111;
        2'd1:    bus.colour_out = 3'b011;
        2'd2:    bus.colour_out = 3'b101;
        default: bus.colour_out = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_board_square_renderer.sv
// Directed bench for board_square_renderer with hand-computed pixel coordinates.
module tb_board_square_renderer;

  logic clock;
  logic reset;

  board_square_renderer_if bus ();

  board_square_renderer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [7:0] cap_x [3600];
  logic [6:0] cap_y [3600];
  logic [2:0] cap_c [3600];
  int n_plot;
  int done_cnt;
  bit gap_seen;
  bit done_ok;
  bit busy_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out};
  endfunction

  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // Samples one frame at negedges; optionally changes grid and pulses start at plot 100.
  task automatic capture_frame(input bit snap_test);
    int  cyc   = 0;
    int  post  = 0;
    bit  ended = 0;
    bit  prev_plot = 0;
    n_plot = 0; done_cnt = 0; gap_seen = 0; done_ok = 0; busy_bad = 0;
    while (cyc < 4000 && !(ended && post >= 6)) begin
      @(negedge clock);
      cyc++;
      if (bus.plot) begin
        if (ended) gap_seen = 1;
        if (n_plot < 3600) begin
          cap_x[n_plot] = bus.x_out;
          cap_y[n_plot] = bus.y_out;
          cap_c[n_plot] = bus.colour_out;
        end
        if (!bus.busy) busy_bad = 1;
        n_plot++;
        if (snap_test && n_plot == 100) begin
          bus.grid  = 18'h3FFFF;
          bus.start = 1'b1;
        end else if (snap_test && n_plot == 101) begin
          bus.start = 1'b0;
        end
      end else if (n_plot > 0) begin
        ended = 1;
        post++;
      end
      if (bus.done) begin
        done_cnt++;
        if (prev_plot && n_plot == 3600 && !bus.busy) done_ok = 1;
      end
      prev_plot = bus.plot;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".plots"}, n_plot, 3600);
    check({tag, ".contiguous"}, gap_seen, 0);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".done_after_last"}, done_ok, 1);
    check({tag, ".busy_in_draw"}, busy_bad, 0);
  endtask

  task automatic check_pixel(input string tag, input int idx,
                             input int ex, input int ey, input logic [2:0] ec);
    check({tag, ".x"}, cap_x[idx], ex);
    check({tag, ".y"}, cap_y[idx], ey);
    check({tag, ".colour"}, cap_c[idx], ec);
  endtask

  initial begin
    int cnt;
    bit bad;
    int seg_len [8];
    bit seg_val [8];
    int nseg;
    int cur_len;
    bit cur_val;

    // Reset held two cycles with start high.
    reset = 1'b1;
    bus.start = 1'b1;
    bus.grid = 18'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("reset.outs_zero", all_outs(), 0);
    end
    bus.start = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("post_reset.outs_zero", all_outs(), 0);
    end

    // All-empty board.
    bus.grid = 18'h0;
    pulse_start();
    capture_frame(0);
    check_frame("empty");
    check_pixel("empty.p0", 0, 37, 7, 3'b111);
    check_pixel("empty.p1", 1, 38, 7, 3'b111);
    check_pixel("empty.p20", 20, 37, 8, 3'b111);
    check_pixel("empty.last", 3599, 116, 86, 3'b111);

    // Mixed board: cell0=O, cell4=X, cell8=unused.
    bus.grid = 18'h10203;
    pulse_start();
    capture_frame(0);
    check_frame("mixed");
    check_pixel("mixed.p0", 0, 37, 7, 3'b011);
    check_pixel("mixed.p1600", 1600, 67, 37, 3'b101);
    check_pixel("mixed.p3200", 3200, 97, 67, 3'b000);
    check_pixel("mixed.p400", 400, 67, 7, 3'b111);

    // Snapshot holds and mid-draw start is ignored.
    bus.grid = 18'h0;
    pulse_start();
    capture_frame(1);
    check_frame("snap");
    bad = 0;
    for (int i = 0; i < 3600; i++) if (cap_c[i] !== 3'b111) bad = 1;
    check("snap.all_white", bad, 0);
    bus.grid = 18'h0;

    // Reset at plot cycle 1000.
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 1100 && cnt < 1000; i++) begin
      @(negedge clock);
      if (bus.plot) cnt++;
    end
    check("rstmid.reached_1000", cnt, 1000);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rstmid.plot", bus.plot, 0);
    check("rstmid.busy", bus.busy, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done || bus.plot) bad = 1;
      @(negedge clock);
    end
    check("rstmid.no_done", bad, 0);
    pulse_start();
    capture_frame(0);
    check_frame("rstmid.redraw");
    check_pixel("rstmid.p0", 0, 37, 7, 3'b111);

    // Back-to-back with start held high.
    @(negedge clock);
    bus.start = 1'b1;
    nseg = 0;
    cur_len = 0;
    cur_val = 0;
    for (int i = 0; i < 3 * 3602 && nseg < 8; i++) begin
      @(negedge clock);
      if (i == 0) begin
        cur_val = bus.plot;
        cur_len = 1;
      end else if (bus.plot == cur_val) begin
        cur_len++;
      end else begin
        seg_len[nseg] = cur_len;
        seg_val[nseg] = cur_val;
        nseg++;
        cur_val = bus.plot;
        cur_len = 1;
      end
    end
    bus.start = 1'b0;
    check("b2b.segments", (nseg >= 4), 1);
    if (nseg >= 4) begin
      check("b2b.first_is_plot", seg_val[0], 1);
      check("b2b.frame0_len", seg_len[0], 3600);
      check("b2b.gap0_len", seg_len[1], 2);
      check("b2b.frame1_len", seg_len[2], 3600);
      check("b2b.gap1_len", seg_len[3], 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
